// File: rtl/request_unit_pkg.sv
// Shared types for the request sequencer: the FSM state encoding and default sizing.
package request_unit_pkg;

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        DATA   = 2'd1,
        HALTED = 2'd2
    } reqstate_t;

    localparam int DEFAULT_WAIT_LIMIT = 64;
    localparam int DEFAULT_CNT_W      = 32;

endpackage

// File: rtl/request_unit_watchdog.sv
// req_watchdog: saturating counter with synchronous clear/enable and a terminal flag
// that pulses on the increment that lands exactly on LIMIT (LIMIT=0 disables it).
module req_watchdog #(
    parameter int W     = 32,
    parameter int LIMIT = 0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] count,
    output logic         terminal
);

    logic at_max;
    assign at_max = &count;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (en && !at_max) begin
            count <= count + W'(1);
        end
    end

    generate
        if (LIMIT == 0) begin : g_no_limit
            assign terminal = 1'b0;
        end else begin : g_limit
            assign terminal = en && !clr && !at_max && ((count + W'(1)) == W'(LIMIT));
        end
    endgenerate

endmodule

// File: rtl/request_unit.sv
// request_unit: fetch/data/halt sequencer for the single-cycle datapath.
// Optional stall statistics ports are enabled by defining REQUEST_UNIT_STATS_EN.
module request_unit
    import request_unit_pkg::*;
#(
    parameter int WAIT_LIMIT = DEFAULT_WAIT_LIMIT,
    parameter int CNT_W      = DEFAULT_CNT_W
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             halt,
    input  logic             dREN,
    input  logic             dWEN,
    input  logic             ihit,
    input  logic             dhit,
    output logic             imemREN,
    output logic             dmemREN,
    output logic             dmemWEN,
    output logic             pc_en,
    output logic             halt_out,
    output logic             req_err,
    output logic             timeout,
`ifdef REQUEST_UNIT_STATS_EN
    output logic [CNT_W-1:0] istall_cnt,
    output logic [CNT_W-1:0] dstall_cnt,
`endif
    output reqstate_t        dbg_state,
    output logic [CNT_W-1:0] dbg_wait_cnt
);

    // Handshake: a request (imemREN/dmemREN/dmemWEN) stays asserted until its hit
    // arrives; the hit completes the transfer in that same cycle, and the request
    // is withdrawn on the following edge. Requests never abort on their own.
    reqstate_t state;
    logic      in_fetch, in_data, wd_terminal;

    assign in_fetch  = (state == FETCH);
    assign in_data   = (state == DATA);
    assign dbg_state = state;

    assign pc_en = !RST && ((in_fetch && ihit && !halt && !dREN && !dWEN) ||
                            (in_data && dhit));

    // Held at zero outside DATA, so it is already clear on entry and clears again on exit.
    req_watchdog #(.W(CNT_W), .LIMIT(WAIT_LIMIT)) u_watchdog (
        .clk      (CLK),
        .rst      (RST),
        .clr      (!in_data || dhit),
        .en       (in_data && !dhit),
        .count    (dbg_wait_cnt),
        .terminal (wd_terminal)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= FETCH;
            imemREN  <= 1'b1;
            dmemREN  <= 1'b0;
            dmemWEN  <= 1'b0;
            halt_out <= 1'b0;
            req_err  <= 1'b0;
            timeout  <= 1'b0;
        end else begin
            case (state)
                FETCH: begin
                    if (ihit && halt) begin
                        state    <= HALTED;
                        imemREN  <= 1'b0;
                        halt_out <= 1'b1;
                    end else if (ihit && (dREN || dWEN)) begin
                        state   <= DATA;
                        imemREN <= 1'b0;
                        dmemWEN <= dWEN;
                        dmemREN <= dREN && !dWEN;
                        if (dREN && dWEN) req_err <= 1'b1;
                    end
                end
                DATA: begin
                    if (dhit) begin
                        state   <= FETCH;
                        imemREN <= 1'b1;
                        dmemREN <= 1'b0;
                        dmemWEN <= 1'b0;
                    end
                    if (wd_terminal) timeout <= 1'b1;
                end
                HALTED: begin
                end
                default: begin
                    state <= FETCH;
                end
            endcase
        end
    end

`ifdef REQUEST_UNIT_STATS_EN
    logic istall_term, dstall_term;

    req_watchdog #(.W(CNT_W), .LIMIT(0)) u_istall (
        .clk      (CLK),
        .rst      (RST),
        .clr      (1'b0),
        .en       (in_fetch && !ihit),
        .count    (istall_cnt),
        .terminal (istall_term)
    );

    req_watchdog #(.W(CNT_W), .LIMIT(0)) u_dstall (
        .clk      (CLK),
        .rst      (RST),
        .clr      (1'b0),
        .en       (in_data && !dhit),
        .count    (dstall_cnt),
        .terminal (dstall_term)
    );
`endif

endmodule

// File: tb/tb_request_unit.sv
// Self-checking bench for request_unit against a rule-level reference model.
module tb_request_unit;
    import request_unit_pkg::*;

    localparam int WL = 4;
    localparam int CW = 8;

    logic CLK = 1'b0;
    logic RST, halt, dREN, dWEN, ihit, dhit;
    logic imemREN, dmemREN, dmemWEN, pc_en, halt_out, req_err, timeout;
    reqstate_t dbg_state;
    logic [CW-1:0] dbg_wait_cnt;
`ifdef REQUEST_UNIT_STATS_EN
    logic [CW-1:0] istall_cnt, dstall_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: halted flag, pending access kind (0 none, 1 read, 2 write),
    // cycles waited on the pending access, sticky flags and stall totals.
    bit m_halted, m_err, m_to;
    int m_kind, m_waits, m_ist, m_dst;

    request_unit #(.WAIT_LIMIT(WL), .CNT_W(CW)) dut (
        .CLK          (CLK),
        .RST          (RST),
        .halt         (halt),
        .dREN         (dREN),
        .dWEN         (dWEN),
        .ihit         (ihit),
        .dhit         (dhit),
        .imemREN      (imemREN),
        .dmemREN      (dmemREN),
        .dmemWEN      (dmemWEN),
        .pc_en        (pc_en),
        .halt_out     (halt_out),
        .req_err      (req_err),
        .timeout      (timeout),
`ifdef REQUEST_UNIT_STATS_EN
        .istall_cnt   (istall_cnt),
        .dstall_cnt   (dstall_cnt),
`endif
        .dbg_state    (dbg_state),
        .dbg_wait_cnt (dbg_wait_cnt)
    );

    // Clock/reset
    always #5 CLK = ~CLK;

    function automatic logic [16:0] dut_vec();
        return {dbg_state, imemREN, dmemREN, dmemWEN, pc_en, halt_out, req_err, timeout, dbg_wait_cnt};
    endfunction

    function automatic logic [16:0] model_vec();
        reqstate_t s;
        logic im, dr, dw, pc;
        logic [CW-1:0] w;
        if (m_halted) begin
            s = HALTED; im = 0; dr = 0; dw = 0; pc = 0; w = '0;
        end else if (m_kind == 0) begin
            s = FETCH; im = 1; dr = 0; dw = 0; w = '0;
            pc = ihit && !halt && !dREN && !dWEN;
        end else begin
            s = DATA; im = 0; dr = (m_kind == 1); dw = (m_kind == 2); pc = dhit;
            w = CW'(m_waits);
        end
        if (RST) pc = 0;
        return {s, im, dr, dw, pc, logic'(m_halted), logic'(m_err), logic'(m_to), w};
    endfunction

    task automatic model_advance();
        if (RST) begin
            m_halted = 0; m_err = 0; m_to = 0; m_kind = 0; m_waits = 0; m_ist = 0; m_dst = 0;
        end else if (!m_halted) begin
            if (m_kind == 0) begin
                if (!ihit) m_ist = (m_ist < 255) ? m_ist + 1 : 255;
                if (ihit && halt) m_halted = 1;
                else if (ihit && (dREN || dWEN)) begin
                    m_kind  = dWEN ? 2 : 1;
                    m_waits = 0;
                    if (dREN && dWEN) m_err = 1;
                end
            end else if (dhit) begin
                m_kind  = 0;
                m_waits = 0;
            end else begin
                m_dst   = (m_dst < 255) ? m_dst + 1 : 255;
                m_waits = (m_waits < 255) ? m_waits + 1 : 255;
                if (m_waits == WL) m_to = 1;
            end
        end
    endtask

    // Driver tasks
    task automatic apply(input logic r, input logic h, input logic rd, input logic wr,
                         input logic ih, input logic dh);
        RST = r; halt = h; dREN = rd; dWEN = wr; ihit = ih; dhit = dh;
        @(negedge CLK);
    endtask

    task automatic tick();
        model_advance();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        apply(1, 0, 0, 0, 0, 0);
        tick();
        apply(1, 0, 1, 0, 1, 1);
        n_checks++;
        if (dut_vec() !== model_vec()) begin
            n_fail++;
            $display("FAIL reset_held got=%h exp=%h", dut_vec(), model_vec());
        end
        tick();
        apply(0, 0, 0, 0, 0, 0);
        n_checks++;
        if (dut_vec() !== model_vec()) begin
            n_fail++;
            $display("FAIL reset_release got=%h exp=%h", dut_vec(), model_vec());
        end
        tick();
    endtask

    task automatic test_nonmem();
        for (int i = 0; i < 3; i++) begin
            apply(0, 0, 0, 0, 1, 0);
            n_checks++;
            if (dut_vec() !== model_vec() || pc_en !== 1'b1) begin
                n_fail++;
                $display("FAIL nonmem step%0d got=%h exp=%h", i, dut_vec(), model_vec());
            end
            tick();
        end
    endtask

    task automatic test_load();
        logic [3:0] dh_seq;
        dh_seq = 4'b1000;
        apply(0, 0, 1, 0, 1, 0);
        tick();
        for (int i = 0; i < 5; i++) begin
            if (i < 4) apply(0, 0, 0, 0, 0, dh_seq[i]);
            else       apply(0, 0, 0, 0, 0, 0);
            n_checks++;
            if (dut_vec() !== model_vec()) begin
                n_fail++;
                $display("FAIL load step%0d got=%h exp=%h", i, dut_vec(), model_vec());
            end
            tick();
        end
    endtask

    task automatic test_both();
        logic [2:0] dh_seq;
        dh_seq = 3'b010;
        apply(0, 0, 1, 1, 1, 0);
        tick();
        for (int i = 0; i < 3; i++) begin
            apply(0, 0, 0, 0, 0, dh_seq[i]);
            n_checks++;
            if (dut_vec() !== model_vec()) begin
                n_fail++;
                $display("FAIL both step%0d got=%h exp=%h", i, dut_vec(), model_vec());
            end
            tick();
        end
    endtask

    task automatic test_timeout();
        apply(0, 0, 0, 1, 1, 0);
        tick();
        for (int i = 0; i < 7; i++) begin
            apply(0, 0, 0, 0, 1, 0);
            n_checks++;
            if (dut_vec() !== model_vec()) begin
                n_fail++;
                $display("FAIL timeout step%0d got=%h exp=%h", i, dut_vec(), model_vec());
            end
            tick();
        end
        apply(1, 0, 0, 0, 0, 0);
        tick();
        apply(0, 0, 0, 0, 0, 0);
        n_checks++;
        if (dut_vec() !== model_vec()) begin
            n_fail++;
            $display("FAIL timeout_reset got=%h exp=%h", dut_vec(), model_vec());
        end
        tick();
    endtask

    task automatic test_random();
        int halted_for;
        logic r, h, rd, wr, ih, dh;
        halted_for = 0;
        for (int i = 0; i < 400; i++) begin
            r  = ($urandom_range(0, 99) < 3) || (halted_for > 5);
            h  = ($urandom_range(0, 99) < 4);
            rd = ($urandom_range(0, 2) == 0);
            wr = ($urandom_range(0, 2) == 0);
            ih = ($urandom_range(0, 9) < 6);
            dh = ($urandom_range(0, 2) == 0);
            apply(r, h, rd, wr, ih, dh);
            n_checks++;
            if (dut_vec() !== model_vec()) begin
                n_fail++;
                $display("FAIL random step%0d got=%h exp=%h", i, dut_vec(), model_vec());
            end
`ifdef REQUEST_UNIT_STATS_EN
            n_checks++;
            if (istall_cnt !== CW'(m_ist) || dstall_cnt !== CW'(m_dst)) begin
                n_fail++;
                $display("FAIL random_stats step%0d got=%0d/%0d exp=%0d/%0d",
                         i, istall_cnt, dstall_cnt, m_ist, m_dst);
            end
`endif
            halted_for = m_halted ? halted_for + 1 : 0;
            tick();
        end
        apply(1, 0, 0, 0, 0, 0);
        tick();
    endtask

    task automatic test_halt();
        apply(0, 1, 1, 0, 1, 0);
        tick();
        for (int i = 0; i < 6; i++) begin
            apply(0, $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
                  $urandom_range(0, 1), $urandom_range(0, 1));
            n_checks++;
            if (dut_vec() !== model_vec() || halt_out !== 1'b1) begin
                n_fail++;
                $display("FAIL halt step%0d got=%h exp=%h", i, dut_vec(), model_vec());
            end
`ifdef REQUEST_UNIT_STATS_EN
            n_checks++;
            if (istall_cnt !== CW'(m_ist) || dstall_cnt !== CW'(m_dst)) begin
                n_fail++;
                $display("FAIL halt_stats step%0d got=%0d/%0d exp=%0d/%0d",
                         i, istall_cnt, dstall_cnt, m_ist, m_dst);
            end
`endif
            tick();
        end
    endtask

    initial begin
        m_halted = 0; m_err = 0; m_to = 0; m_kind = 0; m_waits = 0; m_ist = 0; m_dst = 0;
        RST = 1; halt = 0; dREN = 0; dWEN = 0; ihit = 0; dhit = 0;
        #1;
        test_reset();
        test_nonmem();
        test_load();
        test_both();
        test_timeout();
        test_random();
        test_halt();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
